// File: rtl/ps2_host_transmitter_pkg.sv
// PS/2 shared definitions: frame geometry, 4 MHz timing defaults, transmitter
// FSM state type and the odd-parity helper. Also used by the PS/2 decoder.
package ps2_host_transmitter_pkg;

  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop
  localparam int DATA_BITS  = 8;
  // The start bit is driven from REQUEST. The shift register holds the rest.
  localparam int SHIFT_BITS = FRAME_BITS - 1;

  // Timing defaults for the 4 MHz domain.
  localparam int INHIBIT_CYCLES_100US = 400;
  localparam int TIMEOUT_CYCLES_15MS  = 60000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SEND,
    ST_ACK,
    ST_WAITIDLE
  } tx_state_e;

  function automatic logic oddParity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines. It also
// detects a falling edge of the synchronized clock. Lines idle high, so the
// flops reset to 1 and a reset cannot produce a false fall.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ps2ClkIn, ps2DataIn   raw asynchronous line inputs
//   clkSync, dataSync     synchronized line levels
//   fall                  1 for one cycle when clkSync goes from 1 to 0
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2ClkIn,
  input  logic ps2DataIn,
  output logic clkSync,
  output logic dataSync,
  output logic fall
);

  logic [1:0] clkMeta;
  logic [1:0] dataMeta;
  logic       clkPrev;

  always_ff @(posedge clk) begin
    if (reset) begin
      clkMeta  <= 2'b11;
      dataMeta <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      clkMeta  <= {clkMeta[0], ps2ClkIn};
      dataMeta <= {dataMeta[0], ps2DataIn};
      clkPrev  <= clkMeta[1];
    end
  end

  assign clkSync  = clkMeta[1];
  assign dataSync = dataMeta[1];
  assign fall     = clkPrev & ~clkMeta[1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 sender. The module holds the clock line low to inhibit
// the device, then issues a request-to-send. It shifts out data, parity and
// stop bits on device clock falls and then checks the device ACK.
// Both lines are open-drain: a drive output of 1 pulls the line low.
// Ports:
//   clk, reset                system clock (4 MHz), synchronous active-high reset
//   txData, txStart           byte to send and a 1-cycle request (taken only when idle)
//   busy, done, error         status; done/error are 1-cycle pulses
//   ps2ClkIn, ps2DataIn       raw line levels
//   ps2ClkDrive, ps2DataDrive line pull-downs
//   rxInhibit                 tells the decoder to ignore the line (= busy)
//   stateDbg                  current FSM state
// Handshake: txStart is a single-cycle request. It is accepted only in a
// cycle where busy=0. Completion is reported by exactly one of done/error,
// in the same cycle that busy returns to 0.
import ps2_host_transmitter_pkg::*;

module ps2_host_transmitter #(
  parameter int counterBits   = 16,
  parameter int inhibitCycles = INHIBIT_CYCLES_100US,
  parameter int timeoutCycles = TIMEOUT_CYCLES_15MS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txStart,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  input  logic                 ps2ClkIn,
  input  logic                 ps2DataIn,
  output logic                 ps2ClkDrive,
  output logic                 ps2DataDrive,
  output logic                 rxInhibit,
  output tx_state_e            stateDbg
);

  localparam logic [counterBits-1:0] INHIBIT_LAST = counterBits'(inhibitCycles - 1);
  localparam logic [counterBits-1:0] TIMEOUT_LAST = counterBits'(timeoutCycles - 1);
  localparam logic [counterBits-1:0] CNT_ONE      = counterBits'(1);
  // bitCnt counts falls already seen in SEND. The fall that arrives when
  // bitCnt equals this value is fall 10, which presents the stop bit.
  localparam logic [3:0]             BITCNT_LAST  = 4'(FRAME_BITS - 2);

  tx_state_e              state, stateNext;
  logic [counterBits-1:0] counter, counterNext;
  logic [3:0]             bitCnt, bitCntNext;
  logic [SHIFT_BITS-1:0]  shiftReg, shiftNext;
  logic                   dataDriveR, dataDriveNext;
  logic                   doneR, doneNext;
  logic                   errorR, errorNext;
  logic                   clkSync, dataSync, fall;
  logic                   timedOut;

  ps2_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2ClkIn (ps2ClkIn),
    .ps2DataIn(ps2DataIn),
    .clkSync  (clkSync),
    .dataSync (dataSync),
    .fall     (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      counter    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      dataDriveR <= 1'b0;
      doneR      <= 1'b0;
      errorR     <= 1'b0;
    end else begin
      state      <= stateNext;
      counter    <= counterNext;
      bitCnt     <= bitCntNext;
      shiftReg   <= shiftNext;
      dataDriveR <= dataDriveNext;
      doneR      <= doneNext;
      errorR     <= errorNext;
    end
  end

  always_comb begin
    stateNext     = state;
    counterNext   = counter;
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    dataDriveNext = dataDriveR;
    doneNext      = 1'b0;
    errorNext     = 1'b0;
    timedOut      = (counter == TIMEOUT_LAST);

    case (state)
      ST_IDLE: begin
        dataDriveNext = 1'b0;
        if (txStart) begin
          shiftNext   = {1'b1, oddParity(txData), txData};
          counterNext = '0;
          stateNext   = ST_INHIBIT;
        end
      end

      // The device cannot clock while the host holds the clock low. Any fall
      // seen here is the inhibit itself, so the FSM ignores it.
      ST_INHIBIT: begin
        if (counter == INHIBIT_LAST) begin
          counterNext   = '0;
          dataDriveNext = 1'b1;  // start bit is driven from REQUEST onward
          stateNext     = ST_REQUEST;
        end else begin
          counterNext = counter + CNT_ONE;
        end
      end

      ST_REQUEST: begin
        bitCntNext  = '0;
        counterNext = '0;
        stateNext   = ST_SEND;
      end

      ST_SEND: begin
        if (fall) begin
          // Each fall presents the next bit. The stop bit is 1, so the data
          // line is released.
          dataDriveNext = ~shiftReg[0];
          shiftNext     = {1'b0, shiftReg[SHIFT_BITS-1:1]};
          bitCntNext    = bitCnt + 4'd1;
          counterNext   = '0;
          if (bitCnt == BITCNT_LAST) stateNext = ST_ACK;
        end else if (timedOut) begin
          dataDriveNext = 1'b0;
          errorNext     = 1'b1;
          stateNext     = ST_IDLE;
        end else begin
          counterNext = counter + CNT_ONE;
        end
      end

      ST_ACK: begin
        if (fall) begin
          counterNext = '0;
          if (!dataSync) begin
            stateNext = ST_WAITIDLE;
          end else begin
            errorNext = 1'b1;
            stateNext = ST_IDLE;
          end
        end else if (timedOut) begin
          errorNext = 1'b1;
          stateNext = ST_IDLE;
        end else begin
          counterNext = counter + CNT_ONE;
        end
      end

      ST_WAITIDLE: begin
        if (clkSync && dataSync) begin
          doneNext  = 1'b1;
          stateNext = ST_IDLE;
        end else if (fall) begin
          counterNext = '0;
        end else if (timedOut) begin
          errorNext = 1'b1;
          stateNext = ST_IDLE;
        end else begin
          counterNext = counter + CNT_ONE;
        end
      end

      default: begin
        dataDriveNext = 1'b0;
        stateNext     = ST_IDLE;
      end
    endcase
  end

  assign busy         = (state != ST_IDLE);
  assign rxInhibit    = busy;
  assign done         = doneR;
  assign error        = errorR;
  assign ps2ClkDrive  = (state == ST_INHIBIT);
  assign ps2DataDrive = dataDriveR;
  assign stateDbg     = state;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter. It models a PS/2 device that clocks the
// frame at a 40 us period and samples data on rising edges. Captured frames
// are compared with an arithmetic frame model. A per-cycle process checks
// the status and line outputs.
import ps2_host_transmitter_pkg::*;

module tb_ps2_host_transmitter;

  localparam int INHIBIT = 400;
  localparam int TIMEOUT = 2000;
  localparam int HALF_DEV = 80;  // 20 us at 4 MHz

  localparam int M_ACK     = 0;
  localparam int M_NACK    = 1;
  localparam int M_STALL   = 2;
  localparam int M_RESET   = 3;
  localparam int M_RESTART = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] txData = 8'h00;
  logic       txStart = 1'b0;
  logic       busy, done, error;
  logic       ps2ClkIn, ps2DataIn;
  logic       ps2ClkDrive, ps2DataDrive, rxInhibit;
  tx_state_e  stateDbg;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;

  int checks = 0;
  int failures = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int inhRun = 0;
  int lastInhibit = 0;
  logic prevBusy = 1'b0;
  logic prevDone = 1'b0;
  logic acceptedAtEdge = 1'b0;
  logic [7:0] exp_q[$];

  // Open-drain wired-AND between the host drives and the device.
  assign ps2ClkIn  = devClk & ~ps2ClkDrive;
  assign ps2DataIn = devData & ~ps2DataDrive;

  ps2_host_transmitter #(
    .counterBits  (16),
    .inhibitCycles(INHIBIT),
    .timeoutCycles(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .txData      (txData),
    .txStart     (txStart),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .ps2ClkIn    (ps2ClkIn),
    .ps2DataIn   (ps2DataIn),
    .ps2ClkDrive (ps2ClkDrive),
    .ps2DataDrive(ps2DataDrive),
    .rxInhibit   (rxInhibit),
    .stateDbg    (stateDbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // The frame in wire order: bit 0 is the start bit, then data LSB first,
  // then odd parity, then stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones;
    logic par;
    ones = $countones(d);
    par = ((ones % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  always @(posedge clk) acceptedAtEdge <= txStart && !busy && !reset;

  // per-cycle compare process
  always @(negedge clk) begin
    if (ps2ClkDrive) inhRun++;
    else if (inhRun != 0) begin
      lastInhibit = inhRun;
      inhRun = 0;
    end
    if (done) doneCnt++;
    if (error) errCnt++;
    if (!reset) begin
      check("rx_inhibit", rxInhibit, busy);
      check("pulse_exclusive", done & error, 0);
      if (!busy) check("idle_release", {ps2ClkDrive, ps2DataDrive}, 0);
      if (busy) check("busy_no_pulse", done | error, 0);
      if (acceptedAtEdge) check("busy_after_accept", busy, 1);
      if (busy && !prevBusy) check("busy_needs_accept", acceptedAtEdge, 1);
      if (done | error) check("pulse_ends_busy", prevBusy, 1);
      if (prevDone) check("done_one_cycle", done, 0);
    end
    prevBusy = busy;
    prevDone = done;
  end

  // Driver task. It starts a transfer and then plays the device side.
  task automatic run_frame(input logic [7:0] d, input int mode, input string tag,
                           output logic [10:0] cap);
    int d0, e0, n;
    bit ok;
    cap = '0;
    d0 = doneCnt;
    e0 = errCnt;
    exp_q.push_back(d);
    @(negedge clk);
    txData = d;
    txStart = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_accept_latency"}, ps2ClkDrive, 1);
    @(negedge clk);
    txStart = 1'b0;
    if (mode == M_RESTART) begin
      repeat (10) @(negedge clk);
      txData = 8'h55;
      txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < INHIBIT + 100 && !ok; i++) begin
      @(negedge clk);
      if (ps2DataDrive && !ps2ClkDrive) ok = 1;
    end
    check({tag, "_rts"}, ok, 1);
    if (!ok) return;
    cap[0] = ps2DataIn;
    repeat (40) @(negedge clk);
    check({tag, "_inhibit_len"}, lastInhibit, INHIBIT);
    for (int i = 1; i <= 10; i++) begin
      devClk = 1'b0;
      if (mode == M_STALL && i == 4) begin
        n = 0;
        ok = 0;
        for (int k = 0; k < TIMEOUT + 100 && !ok; k++) begin
          @(posedge clk);
          #1;
          n++;
          if (error) ok = 1;
        end
        check({tag, "_timeout_seen"}, ok, 1);
        // Two synchronizer stages and one registered fall come before the
        // timeout count starts.
        check({tag, "_timeout_cycles"}, n, TIMEOUT + 3);
        check({tag, "_timeout_release"}, {ps2ClkDrive, ps2DataDrive, busy}, 0);
        @(negedge clk);
        devClk = 1'b1;
        repeat (10) @(negedge clk);
        check({tag, "_timeout_no_done"}, doneCnt - d0, 0);
        check({tag, "_timeout_err_once"}, errCnt - e0, 1);
        void'(exp_q.pop_back());
        return;
      end
      repeat (HALF_DEV) @(negedge clk);
      devClk = 1'b1;
      cap[i] = ps2DataIn;
      if (mode == M_RESET && i == 3) begin
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_reset_release"}, {ps2ClkDrive, ps2DataDrive, busy, done, error}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        void'(exp_q.pop_back());
        return;
      end
      repeat (HALF_DEV) @(negedge clk);
    end
    check({tag, "_frame"}, cap, model_frame(exp_q.pop_front()));
    if (mode == M_NACK) begin
      devClk = 1'b0;
      repeat (HALF_DEV) @(negedge clk);
      devClk = 1'b1;
      repeat (20) @(negedge clk);
      check({tag, "_nack_error"}, errCnt - e0, 1);
      check({tag, "_nack_no_done"}, doneCnt - d0, 0);
      check({tag, "_nack_release"}, {ps2ClkDrive, ps2DataDrive, busy}, 0);
    end else begin
      devData = 1'b0;
      repeat (20) @(negedge clk);
      devClk = 1'b0;
      repeat (HALF_DEV) @(negedge clk);
      devClk = 1'b1;
      repeat (20) @(negedge clk);
      check({tag, "_held_until_idle"}, doneCnt - d0, 0);
      devData = 1'b1;
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge clk);
        if (doneCnt != d0) ok = 1;
      end
      repeat (5) @(negedge clk);
      check({tag, "_done_once"}, doneCnt - d0, 1);
      check({tag, "_no_error"}, errCnt - e0, 0);
      check({tag, "_busy_clear"}, busy, 0);
    end
  endtask

  initial begin
    logic [10:0] cap;
    logic [7:0] r;
    // Hand-computed frames that pin the model.
    check("model_ED", model_frame(8'hED), 11'b1_1_11101101_0);
    check("model_00", model_frame(8'h00), 11'b1_1_00000000_0);
    check("model_01", model_frame(8'h01), 11'b1_0_00000001_0);

    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, error, ps2ClkDrive, ps2DataDrive, rxInhibit}, 0);
    check("reset_state", stateDbg, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {busy, ps2ClkDrive, ps2DataDrive}, 0);

    run_frame(8'hED, M_ACK, "ed", cap);
    check("ed_bits", cap, 11'b1_1_11101101_0);
    run_frame(8'h00, M_ACK, "zero", cap);
    check("zero_parity", cap[9], 1);
    run_frame(8'h01, M_ACK, "one", cap);
    check("one_parity", cap[9], 0);
    run_frame(8'hA7, M_NACK, "nack", cap);
    run_frame(8'h3C, M_STALL, "stall", cap);
    run_frame(8'hC3, M_RESTART, "restart", cap);
    check("restart_first_byte", cap[8:1], 8'hC3);
    run_frame(8'h99, M_RESET, "reset", cap);
    run_frame(8'h5A, M_ACK, "after_reset", cap);
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom_range(0, 255));
      run_frame(r, ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, "rand", cap);
    end

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
